// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types and constants for the enemy-tank spawn controller
//
// Purpose: spawn-controller state enum, grid width, spawn point coordinates and
//          the 3x3 neighbourhood test used to decide whether a point is blocked.
// Ports:   none (package).
package tank_pkg;

  localparam int GRID_W = 5;

  localparam logic [GRID_W-1:0] SP_X0 = 5'd0;
  localparam logic [GRID_W-1:0] SP_X1 = 5'd11;
  localparam logic [GRID_W-1:0] SP_X2 = 5'd22;
  localparam logic [GRID_W-1:0] SP_Y  = 5'd0;

  typedef enum logic [2:0] {
    IDLE,
    COOLDOWN,
    SELECT,
    SPAWN,
    WAIT_ACK,
    DONE
  } state_t;

  // True when a and b are at most one grid unit apart (unsigned distance).
  function automatic logic near(input logic [GRID_W-1:0] a, input logic [GRID_W-1:0] b);
    logic [GRID_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return (d[GRID_W-1:1] == '0);
  endfunction

endpackage

// File: rtl/spawn_point_picker.sv
// rtl/spawn_point_picker.sv - combinational rotating search for an unblocked spawn point
//
// Purpose: starting at rotation pointer rp, pick the first of the three spawn
//          points whose 3x3 neighbourhood does not contain the player.
// Ports:   rp          in  2  rotation start index (0..2)
//          mytank_xpos in  5  player x
//          mytank_ypos in  5  player y
//          valid       out 1  an unblocked point exists
//          idx         out 2  chosen point index
//          px, py      out 5  chosen point coordinates
module spawn_point_picker
  import tank_pkg::*;
(
  input  logic [1:0]        rp,
  input  logic [GRID_W-1:0] mytank_xpos,
  input  logic [GRID_W-1:0] mytank_ypos,
  output logic              valid,
  output logic [1:0]        idx,
  output logic [GRID_W-1:0] px,
  output logic [GRID_W-1:0] py
);

  function automatic logic [GRID_W-1:0] point_x(input logic [1:0] i);
    case (i)
      2'd1:    point_x = SP_X1;
      2'd2:    point_x = SP_X2;
      default: point_x = SP_X0;
    endcase
  endfunction

  // (start + offset) mod 3; the offset is at most 2 so one subtraction suffices.
  function automatic logic [1:0] rot(input logic [1:0] start, input logic [1:0] offset);
    logic [2:0] s;
    s = {1'b0, start} + {1'b0, offset};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  logic [3:0] blocked;
  logic [1:0] cand;

  always_comb begin
    blocked    = 4'b1000;  // index 3 is not a spawn point
    blocked[0] = near(mytank_xpos, SP_X0) && near(mytank_ypos, SP_Y);
    blocked[1] = near(mytank_xpos, SP_X1) && near(mytank_ypos, SP_Y);
    blocked[2] = near(mytank_xpos, SP_X2) && near(mytank_ypos, SP_Y);
  end

  // Walk offsets from last to first so the nearest rotation offset wins.
  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = rot(rp, 2'(k));
      if (!blocked[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    px = point_x(idx);
    py = SP_Y;
  end

endmodule

// File: rtl/enytank_spawn_ctrl.sv
// rtl/enytank_spawn_ctrl.sv - enemy-tank spawn sequencer with cooldown, wave budget and ack timeout
//
// Purpose: chooses a free enemy slot and an unblocked spawn point, pulses the
//          slot enable, waits for the slot to come alive, then enforces a
//          cooldown before the next spawn. Tracks the per-wave budget.
// Ports:   clk, rst (async, active high), tick (game tick pulse),
//          game_start (wave start pulse), tank_state[3:0] (slot alive flags),
//          mytank_xpos/ypos (player position),
//          tank_en[3:0] (one-hot spawn pulse), spawn_xpos/ypos (spawn point),
//          remaining (unspawned budget), wave_clear (wave finished level).
module enytank_spawn_ctrl
  import tank_pkg::*;
#(
  parameter int TOTAL_ENEMIES  = 20,
  parameter int COOLDOWN_TICKS = 8,
  parameter int ACK_TICKS      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              game_start,
  input  logic [3:0]        tank_state,
  input  logic [GRID_W-1:0] mytank_xpos,
  input  logic [GRID_W-1:0] mytank_ypos,
  output logic [3:0]        tank_en,
  output logic [GRID_W-1:0] spawn_xpos,
  output logic [GRID_W-1:0] spawn_ypos,
  output logic [4:0]        remaining,
  output logic              wave_clear
);

  localparam logic [4:0] TOTAL     = 5'(TOTAL_ENEMIES);
  localparam logic [3:0] CD_LOAD   = 4'(COOLDOWN_TICKS);
  localparam logic [3:0] ACK_LIMIT = 4'(ACK_TICKS);

  state_t            state, state_next;
  logic [1:0]        slot;
  logic [1:0]        rp;
  logic [3:0]        cd_cnt;
  logic [3:0]        ack_cnt;

  logic              free_found;
  logic [1:0]        free_slot;
  logic              pick_valid;
  logic [1:0]        pick_idx;
  logic [GRID_W-1:0] pick_px, pick_py;

  logic              load_wave, spawn_go, ack_hit, ack_tick, refund, cd_tick;

  spawn_point_picker u_picker (
    .rp          (rp),
    .mytank_xpos (mytank_xpos),
    .mytank_ypos (mytank_ypos),
    .valid       (pick_valid),
    .idx         (pick_idx),
    .px          (pick_px),
    .py          (pick_py)
  );

  // Lowest-index dead slot.
  always_comb begin
    free_found = 1'b1;
    free_slot  = 2'd0;
    casez (tank_state)
      4'b???0: free_slot = 2'd0;
      4'b??01: free_slot = 2'd1;
      4'b?011: free_slot = 2'd2;
      4'b0111: free_slot = 2'd3;
      default: free_found = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A tick arriving in the same cycle as a transition only acts on the state
  // being left; the next state starts counting from the following tick.
  always_comb begin
    state_next = state;
    load_wave  = 1'b0;
    spawn_go   = 1'b0;
    ack_hit    = 1'b0;
    ack_tick   = 1'b0;
    refund     = 1'b0;
    cd_tick    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (game_start) begin
          load_wave  = 1'b1;
          state_next = SELECT;
        end
      end
      COOLDOWN: begin
        if (cd_cnt == 4'd0) begin
          state_next = SELECT;
        end else if (tick) begin
          cd_tick = 1'b1;
          if (cd_cnt == 4'd1) state_next = SELECT;
        end
      end
      SELECT: begin
        if (remaining == 5'd0) begin
          state_next = DONE;
        end else if (free_found && pick_valid) begin
          spawn_go   = 1'b1;
          state_next = SPAWN;
        end
      end
      SPAWN: state_next = WAIT_ACK;
      WAIT_ACK: begin
        // Level check: a slot that died again before being seen counts as no ack.
        if (tank_state[slot]) begin
          ack_hit    = 1'b1;
          state_next = COOLDOWN;
        end else if (tick) begin
          ack_tick = 1'b1;
          if ((ack_cnt + 4'd1) >= ACK_LIMIT) begin
            refund     = 1'b1;
            state_next = SELECT;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered on the SELECT decision edge so tank_en is high
  // exactly during the SPAWN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tank_en    <= 4'b0000;
      spawn_xpos <= SP_X0;
      spawn_ypos <= SP_Y;
      remaining  <= 5'd0;
      wave_clear <= 1'b0;
      slot       <= 2'd0;
      rp         <= 2'd0;
      cd_cnt     <= 4'd0;
      ack_cnt    <= 4'd0;
    end else begin
      tank_en    <= 4'b0000;
      wave_clear <= (state == DONE) && !game_start && (tank_state == 4'b0000);
      if (load_wave) begin
        remaining <= TOTAL;
        cd_cnt    <= 4'd0;
        rp        <= 2'd0;
      end else if (spawn_go) begin
        tank_en    <= 4'b0001 << free_slot;
        spawn_xpos <= pick_px;
        spawn_ypos <= pick_py;
        slot       <= free_slot;
        rp         <= (pick_idx == 2'd2) ? 2'd0 : pick_idx + 2'd1;
        remaining  <= (remaining == 5'd0) ? 5'd0 : remaining - 5'd1;
        ack_cnt    <= 4'd0;
      end else if (ack_hit) begin
        cd_cnt <= CD_LOAD;
      end else if (cd_tick) begin
        cd_cnt <= cd_cnt - 4'd1;
      end else if (ack_tick) begin
        ack_cnt <= ack_cnt + 4'd1;
        if (refund) remaining <= (remaining >= TOTAL) ? TOTAL : remaining + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_enytank_spawn_ctrl.sv
// tb/tb_enytank_spawn_ctrl.sv - self-checking bench for enytank_spawn_ctrl
module tb_enytank_spawn_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default wave (20 enemies, 8-tick cooldown, 2-tick ack timeout)
  logic       rst_a = 1'b1, tick_a, gs_a;
  logic [3:0] ts_a;
  logic [4:0] mx_a, my_a;
  logic [3:0] en_a;
  logic [4:0] sx_a, sy_a, rem_a;
  logic       wc_a;

  enytank_spawn_ctrl #(.TOTAL_ENEMIES(20), .COOLDOWN_TICKS(8), .ACK_TICKS(2)) dut_a (
    .clk(clk), .rst(rst_a), .tick(tick_a), .game_start(gs_a), .tank_state(ts_a),
    .mytank_xpos(mx_a), .mytank_ypos(my_a), .tank_en(en_a), .spawn_xpos(sx_a),
    .spawn_ypos(sy_a), .remaining(rem_a), .wave_clear(wc_a)
  );

  // Instance B: short wave (2 enemies, 1-tick cooldown)
  logic       rst_b = 1'b1, tick_b, gs_b;
  logic [3:0] ts_b;
  logic [4:0] mx_b, my_b;
  logic [3:0] en_b;
  logic [4:0] sx_b, sy_b, rem_b;
  logic       wc_b;

  enytank_spawn_ctrl #(.TOTAL_ENEMIES(2), .COOLDOWN_TICKS(1), .ACK_TICKS(2)) dut_b (
    .clk(clk), .rst(rst_b), .tick(tick_b), .game_start(gs_b), .tank_state(ts_b),
    .mytank_xpos(mx_b), .mytank_ypos(my_b), .tank_en(en_b), .spawn_xpos(sx_b),
    .spawn_ypos(sy_b), .remaining(rem_b), .wave_clear(wc_b)
  );

  typedef struct {
    logic [3:0] en;
    logic [4:0] x, y, rem;
  } exp_t;

  typedef struct {
    logic [4:0] mx, my;
    logic [3:0] ts;
    logic [3:0] en;
    logic [4:0] x, y, rem;
  } step_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input logic [3:0] en, input logic [4:0] x, input logic [4:0] y, input logic [4:0] rem);
    exp_t e;
    e = '{en, x, y, rem};
    q_a.push_back(e);
  endtask

  task automatic expect_b(input logic [3:0] en, input logic [4:0] x, input logic [4:0] y, input logic [4:0] rem);
    exp_t e;
    e = '{en, x, y, rem};
    q_b.push_back(e);
  endtask

  task automatic wait_q_a(input int budget);
    for (int i = 0; i < budget && q_a.size() != 0; i++) clk_step();
    n_cmp++;
    if (q_a.size() != 0) begin
      n_bad++;
      $display("FAIL spawn_a_timeout: got no tank_en within %0d clk, expected a spawn", budget);
      q_a.delete();
    end
  endtask

  task automatic wait_q_b(input int budget);
    for (int i = 0; i < budget && q_b.size() != 0; i++) clk_step();
    n_cmp++;
    if (q_b.size() != 0) begin
      n_bad++;
      $display("FAIL spawn_b_timeout: got no tank_en within %0d clk, expected a spawn", budget);
      q_b.delete();
    end
  endtask

  task automatic pulse_tick_a();
    tick_a = 1'b1;
    clk_step();
    tick_a = 1'b0;
    clk_step();
    clk_step();
  endtask

  task automatic pulse_tick_b();
    tick_b = 1'b1;
    clk_step();
    tick_b = 1'b0;
    clk_step();
    clk_step();
  endtask

  // Scoreboards: every tank_en pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_a && en_a != 4'b0000) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spawn_a_unexpected: got tank_en=%b expected none", en_a);
      end else begin
        e = q_a.pop_front();
        check("spawn_a_en", 32'(en_a), 32'(e.en));
        check("spawn_a_x", 32'(sx_a), 32'(e.x));
        check("spawn_a_y", 32'(sy_a), 32'(e.y));
        check("spawn_a_rem", 32'(rem_a), 32'(e.rem));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_b && en_b != 4'b0000) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spawn_b_unexpected: got tank_en=%b expected none", en_b);
      end else begin
        e = q_b.pop_front();
        check("spawn_b_en", 32'(en_b), 32'(e.en));
        check("spawn_b_x", 32'(sx_b), 32'(e.x));
        check("spawn_b_y", 32'(sy_b), 32'(e.y));
        check("spawn_b_rem", 32'(rem_b), 32'(e.rem));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step_t steps[3];
    steps[0] = '{5'd5,  5'd20, 4'b0001, 4'b0010, 5'd11, 5'd0, 5'd18};
    steps[1] = '{5'd22, 5'd0,  4'b0011, 4'b0100, 5'd0,  5'd0, 5'd17};
    steps[2] = '{5'd11, 5'd1,  4'b0111, 4'b1000, 5'd22, 5'd0, 5'd16};

    tick_a = 0; gs_a = 0; ts_a = 4'b0000; mx_a = 5'd5; my_a = 5'd20;
    tick_b = 0; gs_b = 0; ts_b = 4'b0000; mx_b = 5'd5; my_b = 5'd20;
    clk_step();
    clk_step();

    check("reset_en", 32'(en_a), 32'h0);
    check("reset_x", 32'(sx_a), 32'd0);
    check("reset_y", 32'(sy_a), 32'd0);
    check("reset_rem", 32'(rem_a), 32'd0);
    check("reset_wc", 32'(wc_a), 32'd0);

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) clk_step();
    check("idle_rem", 32'(rem_a), 32'd0);

    // First spawn: two clocks after game_start
    gs_a = 1'b1;
    expect_a(4'b0001, 5'd0, 5'd0, 5'd19);
    clk_step();
    gs_a = 1'b0;
    check("latency_1clk_en", 32'(en_a), 32'h0);
    clk_step();
    check("latency_2clk_en", 32'(en_a), 32'h1);
    wait_q_a(20);

    // Ack previous slot, run full cooldown, expect next spawn only after 8th tick
    for (int i = 0; i < 3; i++) begin
      ts_a = steps[i].ts;
      mx_a = steps[i].mx;
      my_a = steps[i].my;
      clk_step();
      clk_step();
      for (int t = 0; t < 8; t++) begin
        if (t == 7) expect_a(steps[i].en, steps[i].x, steps[i].y, steps[i].rem);
        pulse_tick_a();
      end
      wait_q_a(20);
    end

    // All slots alive with point 0 blocked: SELECT stalls until slot 1 dies
    ts_a = 4'b1111;
    mx_a = 5'd0;
    my_a = 5'd0;
    clk_step();
    clk_step();
    for (int t = 0; t < 8; t++) pulse_tick_a();
    repeat (20) clk_step();
    check("stall_rem", 32'(rem_a), 32'd16);
    check("stall_wc", 32'(wc_a), 32'd0);
    ts_a = 4'b1101;
    expect_a(4'b0010, 5'd11, 5'd0, 5'd15);
    wait_q_a(20);

    // Unacknowledged spawn is refunded after two ticks and retried
    ts_a = 4'b1111;
    mx_a = 5'd5;
    my_a = 5'd20;
    clk_step();
    clk_step();
    for (int t = 0; t < 8; t++) pulse_tick_a();
    repeat (5) clk_step();
    ts_a = 4'b1110;
    expect_a(4'b0001, 5'd22, 5'd0, 5'd14);
    wait_q_a(20);
    tick_a = 1'b1;
    clk_step();
    tick_a = 1'b0;
    clk_step();
    check("noack_tick1_rem", 32'(rem_a), 32'd14);
    tick_a = 1'b1;
    expect_a(4'b0001, 5'd0, 5'd0, 5'd14);
    clk_step();
    tick_a = 1'b0;
    check("refund_rem", 32'(rem_a), 32'd15);
    wait_q_a(20);

    // Short wave on instance B: two spawns, then DONE and wave_clear
    gs_b = 1'b1;
    expect_b(4'b0001, 5'd0, 5'd0, 5'd1);
    clk_step();
    gs_b = 1'b0;
    wait_q_b(20);
    ts_b = 4'b0001;
    clk_step();
    clk_step();
    expect_b(4'b0010, 5'd11, 5'd0, 5'd0);
    pulse_tick_b();
    wait_q_b(20);
    ts_b = 4'b0011;
    clk_step();
    clk_step();
    pulse_tick_b();
    repeat (4) clk_step();
    check("done_rem", 32'(rem_b), 32'd0);
    check("done_alive_wc", 32'(wc_b), 32'd0);
    ts_b = 4'b0000;
    check("wc_lag_before", 32'(wc_b), 32'd0);
    clk_step();
    check("wc_lag_after", 32'(wc_b), 32'd1);

    // Restart from DONE with point 0 blocked, then reset in WAIT_ACK
    mx_b = 5'd0;
    my_b = 5'd0;
    gs_b = 1'b1;
    expect_b(4'b0001, 5'd11, 5'd0, 5'd1);
    clk_step();
    gs_b = 1'b0;
    wait_q_b(20);
    clk_step();
    #2;
    rst_b = 1'b1;
    #1;
    check("async_rst_en", 32'(en_b), 32'h0);
    check("async_rst_x", 32'(sx_b), 32'd0);
    check("async_rst_y", 32'(sy_b), 32'd0);
    check("async_rst_rem", 32'(rem_b), 32'd0);
    check("async_rst_wc", 32'(wc_b), 32'd0);
    clk_step();
    rst_b = 1'b0;
    repeat (5) clk_step();
    check("post_rst_idle_rem", 32'(rem_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/enytank_spawn_ctrl.md
# enytank_spawn_ctrl

Sequences enemy-tank spawning for the four enemy slots. It watches each slot's alive state and the player's position. It enforces a spawn cooldown and a per-wave budget, and rotates through three spawn points, skipping any point the player occupies. It drives the per-slot enables consumed by the enemy-tank application blocks.

## Interface
- TOTAL_ENEMIES, 20: enemies per wave (1..31).
- COOLDOWN_TICKS, 8: ticks between consecutive spawns (1..15).
- ACK_TICKS, 2: ticks to wait for a spawned slot to report alive.
- SP_X0/SP_X1/SP_X2, 0/11/22: spawn point x (grid units).
- SP_Y, 0: spawn row y.
- clk  in  1  system clock (100 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle game-tick pulse (4 Hz rate), synchronous to clk.
- game_start  in  1  one-cycle pulse; starts a wave.
- tank_state  in  4  per-slot alive flag from the enemy-tank blocks.
- mytank_xpos  in  5  player x.
- mytank_ypos  in  5  player y.
- tank_en  out  4  one-hot, one-cycle spawn request to a slot.
- spawn_xpos  out  5  spawn x; valid while tank_en != 0 and held until the next spawn.
- spawn_ypos  out  5  spawn y; same validity.
- remaining  out  5  enemies not yet spawned this wave.
- wave_clear  out  1  level; budget exhausted and all slots dead.

## Operation
- States: IDLE, COOLDOWN, SELECT, SPAWN, WAIT_ACK, DONE.
- IDLE:
  - game_start loads remaining=TOTAL_ENEMIES, cd_cnt=0 and rp=0, where rp is the spawn-point rotation pointer.
  - Go to SELECT; an immediate first spawn is allowed.
- COOLDOWN: each tick decrements cd_cnt. When cd_cnt==0 is reached, go to SELECT.
- SELECT (evaluated every clk):
  - If remaining==0, go to DONE.
  - Otherwise find the lowest-index slot with tank_state==0. If there is none, stay.
  - Otherwise find a spawn point, starting at rp, whose 3x3 neighbourhood excludes the player (|mytank_x−px|≤1 and |mytank_y−py|≤1 means blocked; use unsigned difference).
  - If all three points are blocked, stay.
  - Otherwise latch slot, px and py, set rp=(chosen+1) mod 3, and go to SPAWN.
- SPAWN:
  - Assert tank_en[slot] for exactly one cycle.
  - Update spawn_xpos/ypos in the same cycle; decrement remaining.
  - Go to WAIT_ACK with ack_cnt=0.
- WAIT_ACK:
  - tank_state[slot]==1 → load cd_cnt=COOLDOWN_TICKS and go to COOLDOWN.
  - Otherwise each tick increments ack_cnt. On reaching ACK_TICKS, re-increment remaining (the spawn is refunded) and go to SELECT.
- DONE: wave_clear = (tank_state==0). game_start restarts the wave as from IDLE.
- game_start in any state other than IDLE or DONE is ignored.
- Simultaneous tick and a state transition: the tick is consumed by the state being exited.
- A slot that dies while in WAIT_ACK is treated as unacknowledged.
- remaining never wraps: it saturates at 0 on decrement and at TOTAL_ENEMIES on refund.

## Timing
- Reset values:
  - State IDLE.
  - tank_en=0.
  - spawn_xpos=SP_X0, spawn_ypos=SP_Y.
  - remaining=0, wave_clear=0.
  - cd_cnt=0, ack_cnt=0, rp=0.
- All outputs are registered; there is no combinational input-to-output path.
- game_start to the first tank_en pulse takes 2 clk, provided a slot is free and a point is unblocked.
- A SELECT decision is followed by the tank_en pulse on the next clk.
- Minimum spacing between tank_en pulses is COOLDOWN_TICKS ticks after the ack.
- The wave_clear update lags tank_state by 1 clk.

## Structure
- Shared package tank_pkg holds:
  - the state enum;
  - the spawn point constants SP_X0..SP_X2 and SP_Y;
  - the grid width (5).
- Sub-module spawn_point_picker:
  - Inputs rp, mytank_xpos and mytank_ypos.
  - Outputs valid, idx[1:0], px and py.
  - It is purely combinational; the rotation search and the blocking compare live there.
- The slot priority encoder stays inline.

## Test plan
- Reset, then game_start with the player at (5,20) and tank_state=0 → tank_en=0001 two cycles later, spawn (0,0), remaining=19.
- Slot 0 acks, 8 ticks elapse, then the next spawn → tank_en=0010 at (11,0), no earlier than the 8th tick.
- Player at (11,1) while rp=1 → point 1 skipped, spawn at (22,0), rp becomes 0.
- Player at (0,0) with all slots alive → SELECT stalls and no tank_en occurs until a slot dies.
- Slot never acks and ACK_TICKS=2 → after 2 ticks remaining returns to its pre-spawn value and SELECT retries.
- TOTAL_ENEMIES=2: both spawned, then both slots die → DONE, wave_clear=1 one cycle later; rst asserted mid-WAIT_ACK → all outputs at reset values immediately.
